// File: rtl/rc_filter_pkg.sv
// rc_filter_pkg: shared FSM state type and coefficient/saturation helpers for the RC filter bank.
package rc_filter_pkg;

    typedef enum logic [1:0] {IDLE, MUL, ACC, DONE} state_t;

    // Q16 smoothing factor RC/(RC+DT); DT is 2^32/fs so the C scaling of 2^35 leaves RC in the same 2^32 units after >>3.
    function automatic int alpha_q16(input longint r, input longint c_35_shifted, input longint sample_rate);
        longint dt, rc;
        dt = (longint'(1) << 32) / sample_rate;
        rc = (r * c_35_shifted) >>> 3;
        return int'((rc << 16) / (rc + dt));
    endfunction

    function automatic logic signed [63:0] saturate(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        return value > hi ? hi : (value < lo ? lo : value);
    endfunction

endpackage

// File: rtl/rc_filter_datapath.sv
// rc_filter_datapath: one-channel RC filter arithmetic with a registered multiply stage.
//   clk, reset_n : clock and asynchronous active-low reset
//   load         : capture coef*d into product
//   x, x_prev    : current and previous input sample of the channel
//   y_prev       : previous output sample of the channel
//   coef         : Q16 coefficient (ALPHA for high-pass, BETA for low-pass)
//   product      : registered signed product
//   y            : saturated new output derived from product
module rc_filter_datapath
    import rc_filter_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int LOW_PASS = 0
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    load,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] x_prev,
    input  logic signed [WIDTH-1:0] y_prev,
    input  logic signed [16:0]      coef,
    output logic signed [WIDTH+18:0] product,
    output logic signed [WIDTH-1:0] y
);

    logic signed [WIDTH+1:0] d;
    logic signed [WIDTH+2:0] scaled;
    logic signed [WIDTH+3:0] sum;

    assign d = LOW_PASS != 0 ? (WIDTH+2)'(x) - (WIDTH+2)'(y_prev)
                             : (WIDTH+2)'(y_prev) + (WIDTH+2)'(x) - (WIDTH+2)'(x_prev);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            product <= '0;
        else if (load)
            product <= (WIDTH+19)'(coef) * (WIDTH+19)'(d);
    end

    // Dropping the low 16 bits of a two's complement value is an arithmetic >>>16 (floor).
    assign scaled = product[WIDTH+18:16];
    assign sum    = LOW_PASS != 0 ? (WIDTH+4)'(scaled) + (WIDTH+4)'(y_prev) : (WIDTH+4)'(scaled);
    assign y      = WIDTH'(saturate(64'(sum), WIDTH));

endmodule

// File: rtl/resistor_capacitor_filter_bank.sv
// resistor_capacitor_filter_bank: N-channel first-order RC filter sharing one multiplier.
//   clk          : system clock
//   reset_n      : asynchronous active-low reset
//   audio_clk_en : one-cycle sample strobe
//   in           : CHANNELS signed samples, channel k at [k*WIDTH +: WIDTH]
//   out          : filtered samples, same packing as in
//   out_valid    : one-cycle pulse after all channels are updated
//   overrun      : sticky flag, strobe seen while busy
module resistor_capacitor_filter_bank
    import rc_filter_pkg::*;
#(
    parameter int CLOCK_RATE   = 50000000,
    parameter int SAMPLE_RATE  = 48000,
    parameter int WIDTH        = 16,
    parameter int CHANNELS     = 2,
    parameter int R            = 47000,
    parameter int C_35_SHIFTED = 113387,
    parameter int LOW_PASS     = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      audio_clk_en,
    input  logic [CHANNELS*WIDTH-1:0] in,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic                      out_valid,
    output logic                      overrun
);

    localparam int ALPHA = alpha_q16(R, C_35_SHIFTED, SAMPLE_RATE);
    localparam int BETA  = 65536 - ALPHA;
    localparam logic signed [16:0] COEF = 17'(LOW_PASS != 0 ? BETA : ALPHA);
    localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;

    if (CLOCK_RATE / SAMPLE_RATE < 2 * CHANNELS + 2) begin : g_rate_check
        $error("sample period too short for %0d channels", CHANNELS);
    end
    if (CHANNELS < 1) begin : g_channel_check
        $error("CHANNELS must be at least 1");
    end
    if (WIDTH < 4) begin : g_width_check
        $error("WIDTH must be at least 4");
    end

    state_t state, state_next;
    logic [CW-1:0] ch;
    logic last;
    logic [CHANNELS*WIDTH-1:0] x_cur;
    logic signed [WIDTH-1:0] x_prev [CHANNELS];
    logic signed [WIDTH-1:0] y_prev [CHANNELS];
    logic signed [WIDTH-1:0] x_ch, y;
    logic signed [WIDTH+18:0] product;

    assign last = ch == CW'(CHANNELS - 1);
    assign x_ch = x_cur[ch*WIDTH +: WIDTH];

    rc_filter_datapath #(.WIDTH(WIDTH), .LOW_PASS(LOW_PASS)) u_datapath (
        .clk(clk),
        .reset_n(reset_n),
        .load(state == MUL),
        .x(x_ch),
        .x_prev(x_prev[ch]),
        .y_prev(y_prev[ch]),
        .coef(COEF),
        .product(product),
        .y(y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: state_next = audio_clk_en ? MUL : IDLE;
            MUL:  state_next = ACC;
            ACC:  state_next = last ? DONE : MUL;
            DONE: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ch        <= '0;
            x_cur     <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            overrun   <= 1'b0;
            for (int k = 0; k < CHANNELS; k++) begin
                x_prev[k] <= '0;
                y_prev[k] <= '0;
            end
        end else begin
            // Registered so the pulse lands one cycle after DONE, closing the busy window at 2*CHANNELS+2.
            out_valid <= state == DONE;
            if (audio_clk_en && state != IDLE)
                overrun <= 1'b1;
            if (audio_clk_en && state == IDLE) begin
                x_cur <= in;
                ch    <= '0;
            end
            if (state == ACC) begin
                y_prev[ch]             <= y;
                x_prev[ch]             <= x_ch;
                out[ch*WIDTH +: WIDTH] <= y;
                if (!last)
                    ch <= ch + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_resistor_capacitor_filter_bank.sv
// tb_resistor_capacitor_filter_bank: scoreboard bench for high-pass and low-pass filter bank instances.
module tb_resistor_capacitor_filter_bank;

    localparam int C         = 2;
    localparam int ALPHA_Q16 = 65527;
    localparam int BETA_Q16  = 9;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [31:0] in_h = '0;
    logic [31:0] in_l = {16'd10000, 16'd10000};
    logic [31:0] out_h, out_l;
    logic        valid_h, valid_l, ovr_h, ovr_l;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int t_strobe = 0;
    int lp_prev = 0;
    int hx [2];
    int hy [2];
    int ly [2];
    logic [31:0] hq [$];
    logic [31:0] lq [$];

    resistor_capacitor_filter_bank #(.LOW_PASS(0)) dut_hp (
        .clk(clk), .reset_n(reset_n), .audio_clk_en(en), .in(in_h),
        .out(out_h), .out_valid(valid_h), .overrun(ovr_h)
    );

    resistor_capacitor_filter_bank #(.LOW_PASS(1)) dut_lp (
        .clk(clk), .reset_n(reset_n), .audio_clk_en(en), .in(in_l),
        .out(out_l), .out_valid(valid_l), .overrun(ovr_l)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int floor_q16(input longint a);
        longint q;
        q = a / 65536;
        if (a < 0 && q * 65536 != a) q = q - 1;
        return int'(q);
    endfunction

    function automatic int clamp16(input int v);
        return v > 32767 ? 32767 : (v < -32768 ? -32768 : v);
    endfunction

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic reset_model();
        for (int k = 0; k < 2; k++) begin
            hx[k] = 0;
            hy[k] = 0;
            ly[k] = 0;
        end
        lp_prev = 0;
        hq.delete();
        lq.delete();
    endtask

    // Drive a strobe sampled at the next edge and queue the expected results of both instances.
    task automatic issue(input int x0, input int x1);
        logic [31:0] e_h, e_l;
        logic signed [15:0] xs;
        in_h = {16'(x1), 16'(x0)};
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        t_strobe = cyc;
        for (int k = 0; k < 2; k++) begin
            xs = 16'(k == 0 ? x0 : x1);
            hy[k] = clamp16(floor_q16(longint'(ALPHA_Q16) * longint'(hy[k] + int'(xs) - hx[k])));
            hx[k] = int'(xs);
            ly[k] = clamp16(ly[k] + floor_q16(longint'(BETA_Q16) * longint'(10000 - ly[k])));
            e_h[k*16 +: 16] = 16'(hy[k]);
            e_l[k*16 +: 16] = 16'(ly[k]);
        end
        hq.push_back(e_h);
        lq.push_back(e_l);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((hq.size() != 0 || lq.size() != 0) && i < 40) begin
            @(negedge clk);
            i++;
        end
        chk("drain_timeout", hq.size() + lq.size(), 0);
    endtask

    always @(negedge clk) begin
        if (valid_h) begin
            chk("hp_valid_expected", hq.size() > 0, 1);
            if (hq.size() > 0) chk("hp_out", out_h, hq.pop_front());
            chk("hp_valid_latency", cyc - t_strobe, 2 * C + 1);
        end
        if (valid_l) begin
            chk("lp_valid_expected", lq.size() > 0, 1);
            if (lq.size() > 0) chk("lp_out", out_l, lq.pop_front());
            chk("lp_monotonic", $signed(out_l[15:0]) >= lp_prev && $signed(out_l[15:0]) <= 10000, 1);
            lp_prev = $signed(out_l[15:0]);
        end
    end

    initial begin
        reset_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out", out_h, 0);
        chk("reset_valid", valid_h, 0);
        chk("reset_overrun", ovr_h, 0);
        chk("reset_lp_out", out_l, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;

        issue(1000, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("step_ch0", $signed(out_h[15:0]), 999);
        chk("step_ch1_hold", $signed(out_h[31:16]), 0);
        chk("lp_first", $signed(out_l[15:0]), 1);
        repeat (3) @(posedge clk);
        #1;

        issue(1000, -1000);
        chk("boundary_no_overrun", ovr_h, 0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("neg_mid_ch0", $signed(out_h[15:0]), 998);
        chk("neg_mid_ch1_hold", $signed(out_h[31:16]), 0);
        drain();
        chk("neg_ch1", $signed(out_h[31:16]), -1000);

        @(posedge clk);
        #1;
        issue(32767, -1000);
        drain();
        @(posedge clk);
        #1;
        issue(-32768, -1000);
        drain();
        chk("sat_ch0", $signed(out_h[15:0]), -32768);

        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            issue(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
            drain();
        end

        @(posedge clk);
        #1;
        issue(200, 300);
        @(posedge clk);
        @(posedge clk);
        #1;
        in_h = 32'h1234_5678;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
        chk("overrun_set", ovr_h, 1);
        drain();
        chk("overrun_sticky", ovr_h, 1);

        @(posedge clk);
        #1;
        issue(500, 500);
        @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("midreset_out", out_h, 0);
        chk("midreset_overrun", ovr_h, 0);
        chk("midreset_lp_out", out_l, 0);
        reset_model();
        @(negedge clk);
        chk("midreset_valid", valid_h, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1000, 0);
        drain();
        chk("post_reset_ch0", $signed(out_h[15:0]), 999);
        chk("post_reset_ch1", $signed(out_h[31:16]), 0);
        chk("post_reset_lp", $signed(out_l[15:0]), 1);
        chk("post_reset_overrun", ovr_h, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
